// File: rtl/ifid_skid_reg.sv
// ---------------------------------------------------------------------------
// ifid_skid_reg
//   IF/ID pipeline register built as a two-entry skid buffer. The main entry
//   drives decode; the skid entry catches the one pair that arrives while
//   decode is stalled. Because in_ready comes straight from the skid valid
//   flop, fetch never sees a combinational path from out_ready.
//
//   Parameters
//     PC_W     program-counter width
//     INS_W    instruction width
//     NOP_INS  instruction driven while out_valid is low
//     CNT_W    statistics counter width
//
//   Ports
//     clk, rst_n              clock, asynchronous active-low reset
//     in_valid/in_ready       fetch handshake
//     in_pc, in_ins           fetched pair
//     flush                   branch kill: drops both entries and the
//                             pair presented this cycle
//     out_valid/out_ready     decode handshake
//     out_pc, out_ins         pair to decode (0 / NOP_INS when invalid)
//     bubble_cnt              saturating count of cycles decode asked
//                             for a pair but none was valid
//     flush_cnt               saturating count of flush cycles
// ---------------------------------------------------------------------------

// Saturating event counter: counts up on inc and holds at all-ones.
module ifid_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (inc && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + 1'b1;
    end
endmodule

module ifid_skid_reg #(
    parameter int               PC_W    = 32,
    parameter int               INS_W   = 32,
    parameter logic [INS_W-1:0] NOP_INS = '0,
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [INS_W-1:0] in_ins,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [INS_W-1:0] out_ins,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] ins;
    } pair_t;

    pair_t main_q, main_d;
    pair_t skid_q, skid_d;
    pair_t in_pair;
    logic  main_v, main_v_d;
    logic  skid_v, skid_v_d;
    logic  in_xfer, out_xfer;

    assign in_pair  = '{pc: in_pc, ins: in_ins};
    assign in_ready = ~skid_v;
    assign in_xfer  = in_valid & ~skid_v;
    assign out_xfer = main_v & out_ready;

    // Next-state for both entries. Flush wins over everything; a full skid
    // blocks input, so the only thing that can happen then is skid -> main.
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v;
        skid_v_d = skid_v;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (skid_v) begin
            if (out_xfer) begin
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (!main_v || out_xfer) begin
                main_d   = in_pair;
                main_v_d = 1'b1;
            end else begin
                skid_d   = in_pair;
                skid_v_d = 1'b1;
            end
        end else if (out_xfer) begin
            main_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_v <= main_v_d;
            skid_v <= skid_v_d;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    // Stale payload stays in the flops; mask it so decode sees a clean NOP.
    assign out_valid = main_v;
    assign out_pc    = main_v ? main_q.pc  : '0;
    assign out_ins   = main_v ? main_q.ins : NOP_INS;

    ifid_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_ready & ~main_v),
        .cnt   (bubble_cnt)
    );

    ifid_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Self-checking bench for ifid_skid_reg. The reference is an ordered queue of
// held pairs (capacity two); a second instance with 2-bit counters exercises
// saturation on the same stimulus.
module tb_ifid_skid_reg;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [31:0] in_pc = '0, in_ins = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_ins;
    logic [15:0] bubble_cnt, flush_cnt;
    logic        in_ready2, out_valid2;
    logic [31:0] out_pc2, out_ins2;
    logic [1:0]  bubble_cnt2, flush_cnt2;

    always #5 clk = ~clk;

    ifid_skid_reg #(.PC_W(32), .INS_W(32), .NOP_INS(NOP), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ins(in_ins), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt));

    ifid_skid_reg #(.PC_W(32), .INS_W(32), .NOP_INS(NOP), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_pc(in_pc), .in_ins(in_ins), .flush(flush), .out_valid(out_valid2),
        .out_ready(out_ready), .out_pc(out_pc2), .out_ins(out_ins2),
        .bubble_cnt(bubble_cnt2), .flush_cnt(flush_cnt2));

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } pair_t;

    pair_t exp_q[$];
    int unsigned bc = 0, fc = 0, bc2 = 0, fc2 = 0;
    int n_cmp = 0, n_err = 0;
    bit mon_en = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the model and retires delivered pairs.
    always @(negedge clk) begin
        if (mon_en) begin
            #2;
            check("out_valid", out_valid, exp_q.size() != 0);
            check("in_ready", in_ready, exp_q.size() < 2);
            if (exp_q.size() != 0) begin
                check("out_pc", out_pc, exp_q[0].pc);
                check("out_ins", out_ins, exp_q[0].ins);
            end else begin
                check("out_pc_idle", out_pc, 0);
                check("out_ins_idle", out_ins, NOP);
            end
            check("bubble_cnt", bubble_cnt, bc);
            check("flush_cnt", flush_cnt, fc);
            check("bubble_cnt2", bubble_cnt2, bc2);
            check("flush_cnt2", flush_cnt2, fc2);
            if (out_valid && out_ready && exp_q.size() != 0)
                void'(exp_q.pop_front());
        end
    end

    // One cycle of stimulus; the model decides acceptance from its occupancy
    // before the monitor retires this cycle's delivered pair.
    task automatic cyc(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
        bit acc, bub;
        pair_t p;
        @(negedge clk);
        in_valid = iv; in_pc = pc; in_ins = ins; out_ready = ordy; flush = fl;
        #1;
        acc = iv && (exp_q.size() < 2);
        bub = ordy && (exp_q.size() == 0);
        #2;
        if (fl) exp_q.delete();
        else if (acc) begin
            p.pc = pc; p.ins = ins;
            exp_q.push_back(p);
        end
        if (fl) begin
            if (fc < 65535) fc++;
            if (fc2 < 3) fc2++;
        end
        if (bub) begin
            if (bc < 65535) bc++;
            if (bc2 < 3) bc2++;
        end
    endtask

    // Reset asserted between edges; outputs must respond before the next edge.
    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_ins", out_ins, NOP);
        check("rst_bubble_cnt", bubble_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        exp_q.delete();
        bc = 0; fc = 0; bc2 = 0; fc2 = 0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        mon_en = 1;

        // Bubbles right after reset: 6 cycles -> 6 on 16-bit, 3 on 2-bit.
        repeat (6) cyc(0, 0, 0, 1, 0);
        @(posedge clk); #1;
        check("bubble6", bubble_cnt, 6);
        check("bubble6_sat", bubble_cnt2, 3);

        // Streaming.
        cyc(1, 32'h0, 32'hA0, 1, 0);
        cyc(1, 32'h4, 32'hA4, 1, 0);
        cyc(1, 32'h8, 32'hA8, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);

        // Backpressure: 0x18 is refused while both entries are full.
        cyc(1, 32'h10, 32'hB0, 0, 0);
        cyc(1, 32'h14, 32'hB4, 0, 0);
        cyc(1, 32'h18, 32'hB8, 0, 0);
        @(posedge clk); #1;
        check("bp_in_ready", in_ready, 0);
        repeat (3) cyc(0, 0, 0, 1, 0);

        // Flush with both full and a valid pair presented.
        cyc(1, 32'h30, 32'hC0, 0, 0);
        cyc(1, 32'h34, 32'hC4, 0, 0);
        cyc(1, 32'h20, 32'hC8, 0, 1);
        @(posedge clk); #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_cnt1", flush_cnt, 1);
        repeat (2) cyc(0, 0, 0, 1, 0);

        // Async reset while full.
        cyc(1, 32'h40, 32'hD0, 0, 0);
        cyc(1, 32'h44, 32'hD4, 0, 0);
        do_reset();

        // Random traffic with occasional mid-run resets.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(3, 0) != 0, $urandom, $urandom,
                $urandom_range(1, 0) == 1, $urandom_range(15, 0) == 0);
            if ((i % 700) == 699) do_reset();
        end
        repeat (4) cyc(0, 0, 0, 1, 0);

        @(posedge clk); #1;
        mon_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
